// File: rtl/alu_cikis_asamasi_pkg.sv
// Shared ALU output-stage types: select encoding {en3,en2,en1} and the stored entry layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

    localparam int SEL_W = 3;
    localparam int ALU_W = 32;

    localparam logic [SEL_W-1:0] SEL_A0 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_B0 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_A1 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_B1 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_A2 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_B2 = 3'd5;
    localparam logic [SEL_W-1:0] SEL_A3 = 3'd6;
    localparam logic [SEL_W-1:0] SEL_B3 = 3'd7;

    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             zero;
        logic             neg;
    } alu_entry_t;

endpackage

// File: rtl/alu_cikis_asamasi_if.sv
// Mux-side producer and consumer handshakes of the ALU output stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready, plain valid/ready.
interface alu_cikis_asamasi_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_z;
    logic [SEL_W-1:0]   in_sel;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_zero;
    logic               out_neg;

    // Stage side: accepts in_*, presents out_*.
    modport slave (
        input  in_valid, in_z, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_zero, out_neg
    );

    modport master (
        output in_valid, in_z, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_zero, out_neg
    );

endinterface

// File: rtl/alu_cikis_asamasi_bayrak.sv
// Combinational zero/negative flag generator; only built with ALU_CIKIS_FLAGS_EN.
// Latency: 0 cycles.
// Backpressure: none.
`ifdef ALU_CIKIS_FLAGS_EN
module alu_bayrak_uretici #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             neg
);

    assign zero = (z == '0);
    assign neg  = z[WIDTH-1];

endmodule
`endif

// File: rtl/alu_cikis_asamasi.sv
// Registered FIFO stage after the ALU result mux; flags built only with ALU_CIKIS_FLAGS_EN.
// Latency: 1 cycle from accept into an empty FIFO to out_valid (no fall-through).
// Backpressure: in_ready drops when DEPTH entries are held; derived from registered count only.
module alu_cikis_asamasi
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_cikis_asamasi_if.slave         bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                result_cnt
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [WIDTH-1:0]   mem_data [DEPTH];
    logic [SEL_W-1:0]   mem_sel  [DEPTH];
    logic               push;
    logic               pop;
    alu_entry_t         head;

    assign bus.in_ready  = (count != CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            result_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                result_cnt <= result_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_data[wr_ptr] <= bus.in_z;
            mem_sel[wr_ptr]  <= bus.in_sel;
        end
    end

`ifdef ALU_CIKIS_FLAGS_EN
    logic       in_zero;
    logic       in_neg;
    logic [1:0] mem_flag [DEPTH];

    alu_bayrak_uretici #(.WIDTH(WIDTH)) u_bayrak (
        .z    (bus.in_z),
        .zero (in_zero),
        .neg  (in_neg)
    );

    // Flags travel with the entry so the read side has no compare logic.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_flag[wr_ptr] <= {in_zero, in_neg};
        end
    end
`endif

    always_comb begin
        head = '0;
        if (bus.out_valid) begin
            head.data = ALU_W'(mem_data[rd_ptr]);
            head.sel  = mem_sel[rd_ptr];
`ifdef ALU_CIKIS_FLAGS_EN
            head.zero = mem_flag[rd_ptr][1];
            head.neg  = mem_flag[rd_ptr][0];
`endif
        end
    end

    assign bus.out_data = WIDTH'(head.data);
    assign bus.out_sel  = head.sel;
    assign bus.out_zero = head.zero;
    assign bus.out_neg  = head.neg;

endmodule

// File: tb/tb_alu_cikis_asamasi.sv
// Directed table plus streaming, random back-pressure, counter wrap and mid-run reset sequences.
module tb_alu_cikis_asamasi;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
`ifdef ALU_CIKIS_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  count;
    logic [15:0] result_cnt;

    alu_cikis_asamasi_if #(.WIDTH(WIDTH)) bus ();

    alu_cikis_asamasi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .count      (count),
        .result_cnt (result_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] z;
        logic [2:0]  sel;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [2:0]  e_cnt;
        logic [31:0] e_data;
        logic [2:0]  e_sel;
        logic [15:0] e_rcnt;
    } vec_t;

    vec_t tbl [14];

    logic [34:0] q [$];
    logic [34:0] head;
    logic [15:0] rcnt;
    logic        hold;
    logic        m_rdy, m_vld, do_push, do_pop;
    int          k, pushed, popped, q_n, guard;

    initial begin
        // Expected columns describe the cycle before the row's inputs take effect.
        tbl[0]  = '{1'b1, 32'h0,         SEL_B2, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,         3'd0, 16'd0};
        tbl[1]  = '{1'b0, 32'h0,         3'd0,   1'b1, 1'b1, 1'b1, 3'd1, 32'h0,         3'd5, 16'd0};
        tbl[2]  = '{1'b1, 32'h8000_0001, SEL_A0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,         3'd0, 16'd1};
        tbl[3]  = '{1'b1, 32'h2,         SEL_B0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h8000_0001, 3'd0, 16'd1};
        tbl[4]  = '{1'b1, 32'h3,         SEL_A1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h8000_0001, 3'd0, 16'd1};
        tbl[5]  = '{1'b1, 32'h4,         SEL_B1, 1'b0, 1'b1, 1'b1, 3'd3, 32'h8000_0001, 3'd0, 16'd1};
        tbl[6]  = '{1'b1, 32'h5,         SEL_A2, 1'b0, 1'b0, 1'b1, 3'd4, 32'h8000_0001, 3'd0, 16'd1};
        tbl[7]  = '{1'b1, 32'h5,         SEL_A2, 1'b1, 1'b0, 1'b1, 3'd4, 32'h8000_0001, 3'd0, 16'd1};
        tbl[8]  = '{1'b1, 32'h5,         SEL_A2, 1'b0, 1'b1, 1'b1, 3'd3, 32'h2,         3'd1, 16'd2};
        tbl[9]  = '{1'b0, 32'h0,         3'd0,   1'b1, 1'b0, 1'b1, 3'd4, 32'h2,         3'd1, 16'd2};
        tbl[10] = '{1'b0, 32'h0,         3'd0,   1'b1, 1'b1, 1'b1, 3'd3, 32'h3,         3'd2, 16'd3};
        tbl[11] = '{1'b0, 32'h0,         3'd0,   1'b1, 1'b1, 1'b1, 3'd2, 32'h4,         3'd3, 16'd4};
        tbl[12] = '{1'b0, 32'h0,         3'd0,   1'b1, 1'b1, 1'b1, 3'd1, 32'h5,         3'd4, 16'd5};
        tbl[13] = '{1'b0, 32'h0,         3'd0,   1'b0, 1'b1, 1'b0, 3'd0, 32'h0,         3'd0, 16'd6};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_z      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset out_valid",  32'(bus.out_valid), 32'd0);
        check("reset in_ready",   32'(bus.in_ready),  32'd1);
        check("reset count",      32'(count),         32'd0);
        check("reset result_cnt", 32'(result_cnt),    32'd0);
        check("reset out_data",   bus.out_data,       32'd0);

        for (int i = 0; i < 14; i++) begin
            check($sformatf("row%0d in_ready", i),   32'(bus.in_ready),  32'(tbl[i].e_rdy));
            check($sformatf("row%0d out_valid", i),  32'(bus.out_valid), 32'(tbl[i].e_vld));
            check($sformatf("row%0d count", i),      32'(count),         32'(tbl[i].e_cnt));
            check($sformatf("row%0d out_data", i),   bus.out_data,       tbl[i].e_data);
            check($sformatf("row%0d out_sel", i),    32'(bus.out_sel),   32'(tbl[i].e_sel));
            check($sformatf("row%0d out_zero", i),   32'(bus.out_zero),
                  32'(FLAGS_EN && tbl[i].e_vld && (tbl[i].e_data == 32'h0)));
            check($sformatf("row%0d out_neg", i),    32'(bus.out_neg),
                  32'(FLAGS_EN && tbl[i].e_vld && tbl[i].e_data[31]));
            check($sformatf("row%0d result_cnt", i), 32'(result_cnt),    32'(tbl[i].e_rcnt));
            bus.in_valid  = tbl[i].iv;
            bus.in_z      = tbl[i].z;
            bus.in_sel    = tbl[i].sel;
            bus.out_ready = tbl[i].ordy;
            @(negedge clk);
        end

        // Streaming: one push and one pop per cycle, occupancy pinned at 1.
        for (int i = 0; i < 100; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_z      = 32'(i);
            bus.in_sel    = 3'(i);
            bus.out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("stream%0d count", i),    32'(count),       32'd1);
            check($sformatf("stream%0d out_data", i), bus.out_data,     32'(i));
            check($sformatf("stream%0d out_sel", i),  32'(bus.out_sel), 32'(i % 8));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stream drained count", 32'(count),         32'd0);
        check("stream out_valid",     32'(bus.out_valid), 32'd0);
        check("stream result_cnt",    32'(result_cnt),    32'd106);
        bus.out_ready = 1'b0;

        // Random back-pressure against a queue scoreboard.
        rcnt = 16'd106;
        hold = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!hold) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_z     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                bus.in_sel   = 3'($urandom_range(0, 7));
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            m_rdy = (q.size() != DEPTH);
            m_vld = (q.size() != 0);
            head  = m_vld ? q[0] : 35'h0;
            check("rand in_ready",   32'(bus.in_ready),  32'(m_rdy));
            check("rand out_valid",  32'(bus.out_valid), 32'(m_vld));
            check("rand count",      32'(count),         32'(q.size()));
            check("rand out_data",   bus.out_data,       head[34:3]);
            check("rand out_sel",    32'(bus.out_sel),   32'(head[2:0]));
            check("rand out_zero",   32'(bus.out_zero),  32'(FLAGS_EN && m_vld && (head[34:3] == 32'h0)));
            check("rand out_neg",    32'(bus.out_neg),   32'(FLAGS_EN && m_vld && head[34]));
            check("rand result_cnt", 32'(result_cnt),    32'(rcnt));
            do_push = bus.in_valid && m_rdy;
            do_pop  = m_vld && bus.out_ready;
            if (do_pop) begin
                void'(q.pop_front());
                rcnt = rcnt + 16'd1;
            end
            if (do_push) q.push_back({bus.in_z, bus.in_sel});
            hold = bus.in_valid && !m_rdy;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 2 * DEPTH) begin
            head = q[0];
            check("drain out_data", bus.out_data, head[34:3]);
            void'(q.pop_front());
            rcnt = rcnt + 16'd1;
            guard++;
            @(negedge clk);
        end
        check("drain empty",      32'(q.size()),      32'd0);
        check("drain out_valid",  32'(bus.out_valid), 32'd0);
        check("drain result_cnt", 32'(result_cnt),    32'(rcnt));

        // Stream until result_cnt sits at 0xFFFF, then one more pop must wrap it.
        k      = 65535 - int'(rcnt);
        pushed = 0;
        popped = 0;
        q_n    = 0;
        guard  = 0;
        while (popped < k && guard < 70000) begin
            bus.in_valid = (pushed < k + 1);
            bus.in_z     = 32'(pushed);
            bus.in_sel   = 3'(pushed);
            do_pop  = (q_n != 0);
            do_push = bus.in_valid && (q_n != DEPTH);
            if (do_pop)  begin q_n--; popped++; end
            if (do_push) begin q_n++; pushed++; end
            guard++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("wrap pre result_cnt", 32'(result_cnt),   32'h0000_FFFF);
        check("wrap pre count",      32'(count),        32'd1);
        check("wrap last data",      bus.out_data,      32'(k));
        @(negedge clk);
        check("wrap result_cnt",     32'(result_cnt),   32'd0);
        check("wrap count",          32'(count),        32'd0);
        bus.out_ready = 1'b0;

        // Reset with three entries buffered, alongside a push and a pop.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_z     = 32'hA000_0000 + 32'(i);
            bus.in_sel   = 3'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("midrst pre count", 32'(count), 32'd3);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_z      = 32'hDEAD_BEEF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst count",      32'(count),         32'd0);
        check("midrst out_valid",  32'(bus.out_valid), 32'd0);
        check("midrst in_ready",   32'(bus.in_ready),  32'd1);
        check("midrst result_cnt", 32'(result_cnt),    32'd0);
        check("midrst out_data",   bus.out_data,       32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst after out_valid",  32'(bus.out_valid), 32'd0);
            check("midrst after result_cnt", 32'(result_cnt),    32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cikis_asamasi.md
# alu_cikis_asamasi

Registered output stage that sits directly downstream of the 32-bit 8:1 ALU result multiplexer. It captures the selected result word together with its 3-bit select code, derives status flags, and buffers entries in a small FIFO. It presents them to the consumer over a valid/ready handshake, so that the combinational mux path is decoupled from downstream back-pressure.

## Interface
- WIDTH, 32, data width; equals mux result width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  mux result on in_z is valid this cycle
- in_ready  out  1  stage can accept an entry this cycle
- in_z  in  WIDTH  mux output Z
- in_sel  in  3  select that produced in_z, packed {en3,en2,en1}
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes head entry
- out_data  out  WIDTH  head result word
- out_sel  out  3  head select code
- out_zero  out  1  head result == 0
- out_neg  out  1  head result bit WIDTH-1
- count  out  $clog2(DEPTH)+1  current occupancy
- result_cnt  out  16  total entries delivered; wraps modulo 2^16

## Operation
- Push: in_valid && in_ready → {in_z, in_sel, flags} written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready → rd_ptr increments modulo DEPTH; result_cnt increments (0xFFFF → 0x0000).
- in_ready = (count != DEPTH); out_valid = (count != 0). Both come from registered count only. There is no combinational path from out_ready to in_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal whenever 0 < count < DEPTH.
- When full, in_ready=0. A push presented while a pop happens in the same cycle is not accepted; the producer holds its data and retries.
- When empty, out_data/out_sel/out_zero/out_neg are forced to 0. No fall-through: an entry pushed into an empty FIFO is not visible in the same cycle.
- Flags are computed at push time from in_z and stored with the entry; they are not recomputed at the output.
- Data is never dropped or duplicated. Order is strictly FIFO.
- in_valid with in_ready=0: no state change. The producer must keep in_z/in_sel stable until accepted.

## Timing
- Reset (rst=1 at edge): wr_ptr=0, rd_ptr=0, count=0, result_cnt=0. Then out_valid=0, in_ready=1, and all out_* data/flags read 0. Storage contents are not cleared.
- rst asserted mid-operation discards all buffered entries in that cycle. A push or pop in the same cycle as rst is ignored.
- Latency: an entry accepted at edge N is presented at the output after edge N (out_valid=1 in cycle N+1) if the FIFO was empty.
- Throughput: one entry per cycle sustained when out_ready=1 continuously.
- count, in_ready and out_valid update only on clock edges.

## Configuration
- ALU_CIKIS_FLAGS_EN defined: the zero/negative flags are computed, stored per entry and driven on out_zero/out_neg.
- ALU_CIKIS_FLAGS_EN undefined: no flag storage is built, and out_zero and out_neg are tied to 0. All other behaviour is identical.

## Structure
- A shared package alu_pkg holds the following:
  - SEL_W = 3
  - the select-code constants SEL_A0=3'd0, SEL_B0=3'd1, SEL_A1=3'd2, SEL_B1=3'd3, SEL_A2=3'd4, SEL_B2=3'd5, SEL_A3=3'd6, SEL_B3=3'd7, with the encoding {en3,en2,en1}
  - the packed entry typedef {data, sel, zero, neg}
- One sub-module, alu_bayrak_uretici, is combinational. It maps a WIDTH-bit word to {zero, neg} and is instantiated once on the write side. It is omitted when ALU_CIKIS_FLAGS_EN is undefined.
- The top level holds the storage array, pointers, count and result_cnt.

## Test plan
- Reset then idle: after rst → out_valid=0, in_ready=1, count=0, result_cnt=0, out_data=0.
- Single entry: push in_z=32'h0000_0000, in_sel=3'd5 with out_ready=0. The next cycle shows out_valid=1, out_data=0, out_sel=5, out_zero=1, out_neg=0. Pop → count=0, result_cnt=1.
- Fill to full: push 4 entries (32'h8000_0001, 2, 3, 4) with out_ready=0. Expect count=4 and in_ready=0. A fifth push is held and not accepted. The first pop returns 32'h8000_0001 with out_neg=1.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with incrementing data → count stays at 1, all 100 values are delivered in order, result_cnt=100.
- Random back-pressure: random in_valid/out_ready over 1000 cycles checked against a scoreboard → no loss, no duplication, in order. Preload result_cnt to 0xFFFF and check one more pop wraps it to 0.
- Mid-operation reset: with 3 entries buffered, assert rst for 1 cycle alongside a push and a pop → count=0, out_valid=0, result_cnt=0, and no entry is delivered afterward.
